cp0_timer_exc: RTL

Parametrised CP0 for the 5-stage MIPS core. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and adds a Compare-driven timer interrupt and a configurable number of synchronised hardware interrupt lines. It resolves precise, prioritised exceptions and ERET at the commit (MEM/WB) boundary, then drives a registered pipeline flush with its redirect PC. It replaces the fixed single-width CP0 and sits beside the commit stage, with its MFC0 read port feeding the WB mux.

---
 rtl/cp0_pkg.sv | 58 +++++
 rtl/cp0_timer.sv | 60 ++++++
 rtl/cp0_timer_exc.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, ExcCodes, commit_exc bit indices,
// Status/Cause field positions and read-value packing helpers.
package cp0_pkg;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int EB_ADEL_FETCH = 0;
   localparam int EB_RI         = 1;
   localparam int EB_OV         = 2;
   localparam int EB_SYS        = 3;
   localparam int EB_BP         = 4;
   localparam int EB_ADEL_DATA  = 5;
   localparam int EB_ADES       = 6;

   localparam int ST_BEV    = 22;
   localparam int ST_IM_LO  = 8;
   localparam int ST_EXL    = 1;
   localparam int ST_IE     = 0;
   localparam int CA_BD     = 31;
   localparam int CA_TI     = 30;
   localparam int CA_IP_LO  = 8;
   localparam int CA_EXC_LO = 2;

   // BEV is hard-wired to 1; everything not listed reads as 0.
   function automatic logic [31:0] pack_status(logic [7:0] im, logic exl, logic ie);
      logic [31:0] v;
      v = '0;
      v[ST_BEV] = 1'b1;
      v[ST_IM_LO +: 8] = im;
      v[ST_EXL] = exl;
      v[ST_IE] = ie;
      return v;
   endfunction

   function automatic logic [31:0] pack_cause(logic bd, logic ti, logic [7:0] ip, logic [4:0] code);
      logic [31:0] v;
      v = '0;
      v[CA_BD] = bd;
      v[CA_TI] = ti;
      v[CA_IP_LO +: 8] = ip;
      v[CA_EXC_LO +: 5] = code;
      return v;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and sticky TI.
module cp0_timer
   import cp0_pkg::*;
#(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

   logic [DW-1:0] div;
   logic          wrap;
   logic [31:0]   count_next;
   logic          match;

   // Count's next value; a software write overrides the increment.
   always_comb begin
      wrap = (div == DIV_LAST);
      count_next = count;
      if (count_we)
         count_next = wdata;
      else if (wrap)
         count_next = count + 32'd1;
      // Only a change of Count can raise TI, so a static Count==Compare does
      // not re-assert it after software clears it via Compare.
      match = (count_we || wrap) && (count_next == compare);
   end

   // Divider, Count, Compare and TI state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div     <= '0;
         count   <= '0;
         compare <= '0;
         ti      <= 1'b0;
      end else begin
         if (count_we || wrap)
            div <= '0;
         else
            div <= div + DW'(1);
         count <= count_next;
         if (compare_we) begin
            compare <= wdata;
            ti      <= 1'b0;
         end else if (match) begin
            ti <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_timer_exc.sv
// CP0 register file, interrupt synchroniser, commit-point exception priority
// encoder and registered flush/redirect generation.
module cp0_timer_exc
   import cp0_pkg::*;
#(
   parameter int          HW_INT_NUM = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [HW_INT_NUM-1:0] ext_int,
   input  logic                  commit_valid,
   input  logic [31:0]           commit_pc,
   input  logic                  commit_bd,
   input  logic [6:0]            commit_exc,
   input  logic [31:0]           commit_badvaddr,
   input  logic                  commit_eret,
   input  logic                  mtc0_en,
   input  logic [4:0]            mtc0_addr,
   input  logic [2:0]            mtc0_sel,
   input  logic [31:0]           mtc0_wdata,
   input  logic [4:0]            mfc0_addr,
   input  logic [2:0]            mfc0_sel,
   output logic [31:0]           mfc0_rdata,
   output logic                  flush,
   output logic [31:0]           flush_pc,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           epc_o,
   output logic                  timer_int_o
);

   logic [HW_INT_NUM-1:0] sync1, sync2;
   logic [7:0]  im;
   logic        exl, ie, bd;
   logic [1:0]  ip_sw;
   logic [4:0]  exc_code_r;
   logic [31:0] epc, badvaddr;
   logic [31:0] count, compare;
   logic        ti;

   logic [5:0]  ip_hw;
   logic [7:0]  ip;
   logic        take_int, exc_any, do_eret, do_mtc0;
   logic [6:0]  exc_v;
   logic [4:0]  exc_code;
   logic        bad_we;
   logic [31:0] bad_val;
   logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_we   (wr_count),
      .compare_we (wr_compare),
      .wdata      (mtc0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   // Pending-interrupt view and prioritised exception selection at commit.
   always_comb begin
      ip_hw = '0;
      ip_hw[HW_INT_NUM-1:0] = sync2;
      ip = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
      take_int = commit_valid & ie & ~exl & (|(ip & im));
      exc_v = commit_valid ? commit_exc : 7'd0;
      exc_any = 1'b1;
      exc_code = EXC_INT;
      bad_we = 1'b0;
      bad_val = commit_badvaddr;
      if (take_int) begin
         exc_code = EXC_INT;
      end else if (exc_v[EB_ADEL_FETCH]) begin
         exc_code = EXC_ADEL;
         bad_we = 1'b1;
         bad_val = commit_pc;
      end else if (exc_v[EB_RI]) begin
         exc_code = EXC_RI;
      end else if (exc_v[EB_OV]) begin
         exc_code = EXC_OV;
      end else if (exc_v[EB_SYS]) begin
         exc_code = EXC_SYS;
      end else if (exc_v[EB_BP]) begin
         exc_code = EXC_BP;
      end else if (exc_v[EB_ADEL_DATA]) begin
         exc_code = EXC_ADEL;
         bad_we = 1'b1;
      end else if (exc_v[EB_ADES]) begin
         exc_code = EXC_ADES;
         bad_we = 1'b1;
      end else begin
         exc_any = 1'b0;
      end
      do_eret = commit_valid & commit_eret & ~exc_any;
      do_mtc0 = commit_valid & mtc0_en & ~exc_any & (mtc0_sel == 3'd0);
      wr_count   = do_mtc0 & (mtc0_addr == REG_COUNT);
      wr_compare = do_mtc0 & (mtc0_addr == REG_COMPARE);
      wr_status  = do_mtc0 & (mtc0_addr == REG_STATUS);
      wr_cause   = do_mtc0 & (mtc0_addr == REG_CAUSE);
      wr_epc     = do_mtc0 & (mtc0_addr == REG_EPC);
   end

   // Live register views and the MFC0 read mux.
   always_comb begin
      status_o    = pack_status(im, exl, ie);
      cause_o     = pack_cause(bd, ti, ip, exc_code_r);
      epc_o       = epc;
      timer_int_o = ti;
      mfc0_rdata  = '0;
      if (mfc0_sel == 3'd0) begin
         case (mfc0_addr)
            REG_BADVADDR: mfc0_rdata = badvaddr;
            REG_COUNT:    mfc0_rdata = count;
            REG_COMPARE:  mfc0_rdata = compare;
            REG_STATUS:   mfc0_rdata = status_o;
            REG_CAUSE:    mfc0_rdata = cause_o;
            REG_EPC:      mfc0_rdata = epc;
            default:      mfc0_rdata = '0;
         endcase
      end
   end

   // Two-flop synchroniser for the asynchronous interrupt lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= ext_int;
         sync2 <= sync1;
      end
   end

   // Status, Cause, EPC and BadVAddr updates; exceptions outrank ERET/MTC0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         im         <= '0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         bd         <= 1'b0;
         ip_sw      <= '0;
         exc_code_r <= '0;
         epc        <= '0;
         badvaddr   <= '0;
      end else if (exc_any) begin
         exc_code_r <= exc_code;
         exl        <= 1'b1;
         if (!exl) begin
            epc <= commit_bd ? commit_pc - 32'd4 : commit_pc;
            bd  <= commit_bd;
         end
         if (bad_we)
            badvaddr <= bad_val;
      end else begin
         if (do_eret)
            exl <= 1'b0;
         if (wr_status) begin
            im  <= mtc0_wdata[ST_IM_LO +: 8];
            exl <= mtc0_wdata[ST_EXL];
            ie  <= mtc0_wdata[ST_IE];
         end
         if (wr_cause)
            ip_sw <= mtc0_wdata[CA_IP_LO +: 2];
         if (wr_epc)
            epc <= mtc0_wdata;
      end
   end

   // Registered one-cycle flush with its redirect target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush    <= 1'b0;
         flush_pc <= '0;
      end else begin
         flush    <= exc_any | do_eret;
         flush_pc <= exc_any ? EXC_VECTOR : (do_eret ? epc : 32'd0);
      end
   end

endmodule
